micro_sequencer: RTL
====================

Name: micro_sequencer

Overview:
- Parametrised control unit for the micro-CPU datapath: fetch, decode and execute sequencing with an internal timing-state machine.
- The execute strobe is generated internally rather than supplied externally.
- Adds multi-cycle repeated shifts, a flag latched at decode time, and a HALT instruction.
- Sits between program memory and the A/B/shifter/ALU/accumulator/output registers; drives the 13-bit control word.

Parameters:
- OP_W, 4, opcode field width (instr[DATA_W-1 -: OP_W])
- ARG_W, 4, argument field width (instr[ARG_W-1:0]); DATA_W = OP_W + ARG_W
- REP_W, 3, repeat-counter width for shift ops; REP_W <= ARG_W

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = execute instructions
- instr  in  DATA_W  instruction word from program memory
- instr_valid  in  1  instr is valid this cycle
- flag  in  1  accumulator condition flag
- instr_req  out  1  fetch request to program memory
- ir_load  out  1  one-cycle pulse; instruction register captured
- pc_inc  out  1  one-cycle pulse; advance program counter
- ctrl  out  13  datapath control word C0..C12 (bit n = Cn)
- t_state  out  2  current state encoding
- halted  out  1  HALT executed

Behaviour:
- Reset values: all outputs 0, state IDLE, IR 0, repeat counter 0, latched flag 0. Reset is asynchronous and may be asserted in any state, including mid-EXEC; every output reads 0 immediately on assertion.

States (t_state encoding):
- IDLE (0):
  - If run=1 and halted=0, go to FETCH next cycle.
  - halted clears only on reset.
- FETCH (1):
  - instr_req=1.
  - If instr_valid=1: IR <= instr, ir_load=1, go to DECODE.
  - Otherwise wait; no timeout.
- DECODE (2):
  - flag_q <= flag.
  - rep <= arg[REP_W-1:0] for opcodes 3..6, else 0.
  - ctrl carries only non-enable steer/config bits. Enable bits (C0, C1, C2, C6, C11, C12) are 0.
  - Go to EXEC.
- EXEC (3):
  - Full control word asserted, enables included.
  - If rep != 0: rep <= rep-1, remain in EXEC.
  - If rep == 0: pc_inc=1, then:
    - HALT → IDLE with halted <= 1
    - else run=1 → FETCH
    - else IDLE.
  - Shift ops therefore hold C6 for arg+1 consecutive cycles; rep=0 means 1 cycle, rep max means 2^REP_W cycles.

Opcode decode (one-hot Z on opcode; E = 1 in EXEC only):
- C0 = Z0&E: load A
- C1 = Z1&E: load B
- C2 = Z2&E: load output
- C3 = Z4: steer B to shifter
- C4 = Z3|Z4|Z6
- C5 = Z3|Z4|Z5
- C6 = (Z3|Z4|Z5|Z6)&E
- C7 = Z7: steer A to ALU
- C10:C8 = opcode[2:0] for opcodes 8..14, else 0
- C11 = (((Z7|Z8)&flag_q) | Z9..Z14)&E. Conditional ops use flag_q, never the live flag.
- C12 = Z15&E: output accumulator

HALT and run handling:
- HALT = opcode 15 with arg all-ones. It still asserts C12 for its EXEC cycle.
- run drop mid-instruction: the current instruction completes (including remaining repeats), then the block goes to IDLE. run is sampled only at the end of EXEC and in IDLE.
- instr_valid outside FETCH is ignored.
- Opcodes with OP_W>4 beyond 15 decode as NOP: one EXEC cycle, ctrl=0, pc_inc=1.

Latency:
- Single-cycle-exec instruction, memory answering on the first FETCH cycle: 3 cycles (FETCH, DECODE, EXEC).
- Shift with arg=k: 3+k cycles.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - The transition from EXEC to FETCH is replaced by EXEC → IDLE.
  - IDLE → FETCH requires run=1 and a step rising edge, detected with a registered previous value that resets to 0.
  - One instruction executes per step edge.
- When undefined: no step port; behaviour as above.

Test Plan:
- Reset mid-EXEC of a shift (opcode 3, arg 5) → ctrl=0, t_state=0, instr_req=0 immediately; after release plus run=1, FETCH is reached within 1 cycle.
- run=1, instr=0x00 valid on the first FETCH cycle → ir_load in cycle 1, ctrl=0x0001 for exactly one cycle in cycle 3, pc_inc coincident with it.
- instr=0x45 (opcode 4, arg 5) → ctrl=0x0078 for 6 consecutive EXEC cycles, pc_inc on the 6th only.
- instr=0x70 with flag=1 at DECODE and flag=0 during EXEC → C11 and C7 asserted (ctrl=0x0880). Repeat with flag=0 at DECODE → ctrl=0x0080.
- instr=0xFF → C12 for one cycle, pc_inc, then halted=1, t_state=0; stays idle with run=1 until reset.
- Fetch stall: instr_valid held low 4 cycles → instr_req stays 1, t_state stays 1, ctrl=0 throughout.

Source files
------------

// File: rtl/micro_sequencer.sv
// micro_sequencer: fetch/decode/exec control unit for the micro-CPU datapath.
// Drives the 13-bit control word C0..C12, PC increment and IR load.
// Ports: clk, reset (async, active-high), run, instr, instr_valid, flag,
//   [step when SEQ_SINGLE_STEP_EN], instr_req, ir_load, pc_inc,
//   ctrl[12:0], t_state[1:0], halted.
// Optional macro SEQ_SINGLE_STEP_EN: one instruction per step rising edge.
module micro_sequencer #(
  parameter int OP_W  = 4,
  parameter int ARG_W = 4,
  parameter int REP_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [OP_W+ARG_W-1:0] instr,
  input  logic                  instr_valid,
  input  logic                  flag,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic                  instr_req,
  output logic                  ir_load,
  output logic                  pc_inc,
  output logic [12:0]           ctrl,
  output logic [1:0]            t_state,
  output logic                  halted
);

  localparam int DATA_W = OP_W + ARG_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_DECODE = 2'd2,
    S_EXEC   = 2'd3
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_ir;
  logic [REP_W-1:0]   r_rep;
  logic               r_flag_q;
  logic               r_halted;

  logic [OP_W-1:0]    w_op;
  logic [ARG_W-1:0]   w_arg;
  logic [15:0]        w_z;
  logic               w_shift;
  logic               w_alu;
  logic               w_halt_op;
  logic               w_e;
  logic               w_steer;
  logic               w_go;
  logic               w_cont;

  assign w_op  = r_ir[DATA_W-1 -: OP_W];
  assign w_arg = r_ir[ARG_W-1:0];

  // One-hot opcode; opcodes above 15 leave every bit clear (NOP).
  always_comb begin
    w_z = '0;
    for (int i = 0; i < 16; i++)
      w_z[i] = (w_op == OP_W'(i));
  end

  assign w_shift   = |w_z[6:3];
  assign w_alu     = |w_z[14:8];
  assign w_halt_op = w_z[15] && (w_arg == '1);

  assign w_e     = (r_state == S_EXEC);
  // Steer/config bits are valid from DECODE so the datapath settles early.
  assign w_steer = w_e || (r_state == S_DECODE);

`ifdef SEQ_SINGLE_STEP_EN
  logic r_step_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_step_q <= 1'b0;
    else       r_step_q <= step;
  end
  assign w_go   = run && !r_halted && step && !r_step_q;
  assign w_cont = 1'b0;
`else
  assign w_go   = run && !r_halted;
  assign w_cont = run;
`endif

  always_comb begin
    ctrl       = '0;
    ctrl[0]    = w_z[0] && w_e;
    ctrl[1]    = w_z[1] && w_e;
    ctrl[2]    = w_z[2] && w_e;
    ctrl[3]    = w_z[4] && w_steer;
    ctrl[4]    = (w_z[3] || w_z[4] || w_z[6]) && w_steer;
    ctrl[5]    = (w_z[3] || w_z[4] || w_z[5]) && w_steer;
    ctrl[6]    = w_shift && w_e;
    ctrl[7]    = w_z[7] && w_steer;
    ctrl[10:8] = (w_alu && w_steer) ? w_op[2:0] : 3'd0;
    // Conditional ops use the flag captured at DECODE, not the live one.
    ctrl[11]   = (((w_z[7] || w_z[8]) && r_flag_q) || (|w_z[14:9])) && w_e;
    ctrl[12]   = w_z[15] && w_e;
  end

  assign instr_req = (r_state == S_FETCH);
  assign ir_load   = (r_state == S_FETCH) && instr_valid;
  assign pc_inc    = w_e && (r_rep == '0);
  assign t_state   = r_state;
  assign halted    = r_halted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ir     <= '0;
      r_rep    <= '0;
      r_flag_q <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_go) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_flag_q <= flag;
          r_rep    <= w_shift ? w_arg[REP_W-1:0] : '0;
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          if (r_rep != '0) begin
            r_rep <= r_rep - REP_W'(1);
          end else if (w_halt_op) begin
            r_halted <= 1'b1;
            r_state  <= S_IDLE;
          end else if (w_cont) begin
            r_state <= S_FETCH;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
